// File: rtl/gray_conv_seq.sv
// rtl/gray_conv_seq.sv - handshaked binary/Gray converter with chunked Gray->binary and Gray increment
// Optional dout_par output (XOR of dout) is enabled by defining GRAY_PARITY_EN.
module gray_conv_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
`ifdef GRAY_PARITY_EN
  ,
  output logic             dout_par
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  localparam logic [1:0] M_B2G  = 2'b00;
  localparam logic [1:0] M_G2B  = 2'b01;
  localparam logic [1:0] M_GINC = 2'b10;
  localparam logic [1:0] M_PASS = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_bin;
  logic             r_par;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_dout;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_dout_ld;
  logic [CHUNK-1:0] w_bchunk;
  logic             w_p;
  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_inc;

  // r_g is shifted left each CONV cycle, so the chunk being resolved is always at the top.
  always_comb begin
    w_p      = r_par;
    w_bchunk = '0;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      w_p         = w_p ^ r_g[WIDTH-CHUNK+j];
      w_bchunk[j] = w_p;
    end
  end

  assign w_bin_nxt = (r_bin << CHUNK) | WIDTH'(w_bchunk);
  assign w_inc     = r_bin + WIDTH'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = r_dout;
    w_dout_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (mode == M_B2G || mode == M_PASS) begin
            w_dout_nxt  = (mode == M_B2G) ? (din ^ (din >> 1)) : din;
            w_dout_ld   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CONV;
          end
        end
      end
      S_CONV: begin
        if (r_idx == LAST_IDX) begin
          if (r_mode == M_G2B) begin
            w_dout_nxt  = w_bin_nxt;
            w_dout_ld   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        w_dout_nxt  = w_inc ^ (w_inc >> 1);
        w_dout_ld   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= M_B2G;
      r_g         <= '0;
      r_bin       <= '0;
      r_par       <= 1'b0;
      r_idx       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_dout_ld) begin
        r_dout <= w_dout_nxt;
      end
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mode <= mode;
            r_g    <= din;
            r_bin  <= '0;
            r_par  <= 1'b0;
            r_idx  <= '0;
          end
        end
        S_CONV: begin
          r_g   <= r_g << CHUNK;
          r_bin <= w_bin_nxt;
          r_par <= w_p;
          r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef GRAY_PARITY_EN
  logic r_dout_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_par <= 1'b0;
    end else if (w_dout_ld) begin
      r_dout_par <= ^w_dout_nxt;
    end
  end

  assign dout_par = r_dout_par;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CONV) || (r_state == S_FIN);
  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule
